// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W       = 64;
    localparam int unsigned DEF_CACHE_DATA_W = 64;
    localparam int unsigned DEF_INSTR_W      = 32;

    // Byte distance between consecutive instructions.
    localparam int unsigned PC_STEP = DEF_INSTR_W / 8;
    // Instructions carried by one cache response.
    localparam int unsigned LANES   = DEF_CACHE_DATA_W / DEF_INSTR_W;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Issue control: either free to issue or waiting on the single outstanding request.
    typedef enum logic {
        StIdle,
        StWaitResp
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry read straight from the storage registers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop frees the slot a simultaneous push at full writes into.
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Decoupled fetch stage: owns the fetch PC, keeps one I-cache request in flight while the
// prefetch queue has a free slot, and streams fetched instructions to decode.
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W       = DEF_ADDR_W,
    parameter int unsigned      CACHE_DATA_W = DEF_CACHE_DATA_W,
    parameter int unsigned      INSTR_W      = DEF_INSTR_W,
    parameter int unsigned      QDEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_enable,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    cache_req_valid,
    output logic [ADDR_W-1:0]       cache_req_addr,
    input  logic                    cache_resp_valid,
    input  logic [CACHE_DATA_W-1:0] cache_resp_data,
    output logic                    id_valid,
    output logic [INSTR_W-1:0]      id_instr,
    output logic [ADDR_W-1:0]       id_pc,
    input  logic                    id_ready
);

    localparam int unsigned STEP     = INSTR_W / 8;
    localparam int unsigned NLANES   = CACHE_DATA_W / INSTR_W;
    localparam int unsigned LANE_LSB = $clog2(STEP);
    localparam int unsigned LANE_W   = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned ENTRY_W  = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W    = $clog2(QDEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                drop_pending_q, drop_pending_d;
    logic                push;
    logic                pop;
    logic [LANE_W-1:0]   lane;
    logic [INSTR_W-1:0]  resp_instr;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                unused_full;

    assign unused_full = fifo_full;

    // Lane of the response line that holds the instruction at fetch_pc.
    if (NLANES > 1) begin : g_lane
        assign lane = fetch_pc_q[LANE_LSB +: LANE_W];
    end else begin : g_one_lane
        assign lane = '0;
    end

    // Select the addressed instruction out of the cache line.
    always_comb begin
        resp_instr = cache_resp_data[INSTR_W-1:0];
        for (int i = 0; i < int'(NLANES); i++) begin
            if (lane == LANE_W'(i)) begin
                resp_instr = cache_resp_data[i*INSTR_W +: INSTR_W];
            end
        end
    end

    // Issue / response / redirect control; redirect overrides everything in its cycle.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_addr_d     = req_addr_q;
        drop_pending_d = drop_pending_q;
        push           = 1'b0;
        unique case (state_q)
            StIdle: begin
                // With nothing in flight the queue count equals the reserved-slot count.
                if (!redirect_valid && fetch_enable && (fifo_count < CNT_W'(QDEPTH))) begin
                    state_d    = StWaitResp;
                    req_addr_d = fetch_pc_q;
                end
            end
            StWaitResp: begin
                if (cache_resp_valid) begin
                    state_d        = StIdle;
                    drop_pending_d = 1'b0;
                    if (!drop_pending_q && !redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(STEP);
                    end
                end else if (redirect_valid) begin
                    // The cache cannot abort, so its eventual response must be thrown away.
                    drop_pending_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            fetch_pc_q     <= RESET_PC;
            req_addr_q     <= '0;
            drop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            req_addr_q     <= req_addr_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    assign pop = !fifo_empty && id_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({fetch_pc_q, resp_instr}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cache_req_valid = (state_q == StWaitResp);
    assign cache_req_addr  = req_addr_q;
    assign id_valid        = !fifo_empty;
    assign id_pc           = head[ENTRY_W-1 -: ADDR_W];
    assign id_instr        = head[INSTR_W-1:0];

endmodule
